// File: rtl/nor_share_arbiter.sv
// nor_share_arbiter: round-robin sequencer that time-shares one external NOR gate
// among NREQ requesters. Each granted operation latches the requester's operands,
// holds them on the gate for SETTLE_CYCLES, then returns the sampled result tagged
// with the requester id. Every sample is checked against the expected NOR, and any
// mismatch sets a sticky error flag.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   req, a_in, b_in      per-requester request level and operands
//   gnt                  one-hot grant, 1-cycle pulse
//   nor_a, nor_b         registered drive into the shared gate
//   nor_y                shared gate output
//   rsp_valid/id/y       result strobe, owner id, sampled nor_y
//   busy                 high while an operation is being driven
//   err                  sticky mismatch flag, cleared only by reset
module nor_share_arbiter #(
   parameter int unsigned NREQ          = 4,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0]           a_in,
   input  logic [NREQ-1:0]           b_in,
   output logic [NREQ-1:0]           gnt,
   output logic                      nor_a,
   output logic                      nor_b,
   input  logic                      nor_y,
   output logic                      rsp_valid,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic                      rsp_y,
   output logic                      busy,
   output logic                      err
);

   localparam int unsigned ID_W  = $clog2(NREQ);
   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] DRIVE = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             nor_a_q, nor_a_d;
   logic             nor_b_q, nor_b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic             rsp_y_q, rsp_y_d;
   logic             err_q, err_d;

   logic [ID_W-1:0]  win_c;
   logic             any_c;

   // Round-robin search: first set request starting at rr_ptr, wrapping mod NREQ.
   always_comb begin
      logic [31:0]     idx;
      logic [ID_W-1:0] cand;
      win_c = '0;
      any_c = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx  = (32'(rr_ptr_q) + i) % NREQ;
         cand = ID_W'(idx);
         if (!any_c && req[cand]) begin
            any_c = 1'b1;
            win_c = cand;
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      id_d        = id_q;
      gnt_d       = '0;
      nor_a_d     = nor_a_q;
      nor_b_d     = nor_b_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_y_d     = rsp_y_q;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (any_c) begin
               gnt_d    = NREQ'(1) << win_c;
               nor_a_d  = a_in[win_c];
               nor_b_d  = b_in[win_c];
               id_d     = win_c;
               rr_ptr_d = (win_c == ID_W'(NREQ - 1)) ? '0 : win_c + ID_W'(1);
               cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_y_d     = nor_y;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               // Result is still reported on mismatch; only the flag records it.
               if (nor_y != ~(nor_a_q | nor_b_q)) err_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         id_q        <= '0;
         gnt_q       <= '0;
         nor_a_q     <= 1'b0;
         nor_b_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_y_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         id_q        <= id_d;
         gnt_q       <= gnt_d;
         nor_a_q     <= nor_a_d;
         nor_b_q     <= nor_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_y_q     <= rsp_y_d;
         err_q       <= err_d;
      end
   end

   assign gnt       = gnt_q;
   assign nor_a     = nor_a_q;
   assign nor_b     = nor_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;
   assign busy      = (state_q == DRIVE);
   assign err       = err_q;

endmodule

// File: tb/tb_nor_share_arbiter.sv
// Directed bench for nor_share_arbiter: one instance with SETTLE_CYCLES=1 and one
// with SETTLE_CYCLES=3, each driving a behavioural NOR gate model.
module tb_nor_share_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance with SETTLE_CYCLES=1
   logic [3:0] req, a_in, b_in, gnt;
   logic       nor_a, nor_b, nor_y, rsp_valid, rsp_y, busy, err;
   logic [1:0] rsp_id;
   logic       force_y = 1'b0;
   assign nor_y = force_y ? 1'b1 : ~(nor_a | nor_b);

   // Instance with SETTLE_CYCLES=3
   logic [3:0] req3, a3, b3, gnt3;
   logic       nor_a3, nor_b3, nor_y3, rsp_valid3, rsp_y3, busy3, err3;
   logic [1:0] rsp_id3;
   assign nor_y3 = ~(nor_a3 | nor_b3);

   nor_share_arbiter #(.NREQ(4), .SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
      .nor_a(nor_a), .nor_b(nor_b), .nor_y(nor_y), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy), .err(err));

   nor_share_arbiter #(.NREQ(4), .SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .a_in(a3), .b_in(b3), .gnt(gnt3),
      .nor_a(nor_a3), .nor_b(nor_b3), .nor_y(nor_y3), .rsp_valid(rsp_valid3),
      .rsp_id(rsp_id3), .rsp_y(rsp_y3), .busy(busy3), .err(err3));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   logic [3:0] exp_gnt;
   logic       exp_y;
   int         order [5] = '{0, 1, 2, 3, 0};

   initial begin
      req = '0; a_in = '0; b_in = '0;
      req3 = '0; a3 = '0; b3 = '0;

      // 1. Reset state
      tick(); tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_nor_ab", {30'h0, nor_a, nor_b}, 32'h0);
      chk("rst_gnt_idle", 32'(gnt), 32'h0);

      // 2. Single op from requester 1, operands 0/0
      req = 4'b0010; a_in = 4'b0000; b_in = 4'b0000;
      tick();
      req = '0;
      chk("op1_gnt", 32'(gnt), 32'h2);
      chk("op1_busy", 32'(busy), 32'h1);
      chk("op1_no_rsp_yet", 32'(rsp_valid), 32'h0);
      tick();
      chk("op1_gnt_pulse", 32'(gnt), 32'h0);
      chk("op1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("op1_rsp_id", 32'(rsp_id), 32'h1);
      chk("op1_rsp_y", 32'(rsp_y), 32'h1);
      chk("op1_busy_done", 32'(busy), 32'h0);
      tick();
      chk("op1_rsp_pulse", 32'(rsp_valid), 32'h0);

      // 3. All requesting, from rr_ptr=0: grants 0,1,2,3,0
      pulse_reset();
      req = 4'b1111; a_in = 4'b1010; b_in = 4'b1100;
      for (int k = 0; k < 5; k++) begin
         exp_gnt = 4'b0001 << order[k];
         exp_y   = ~(a_in[order[k]] | b_in[order[k]]);
         tick();
         chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(exp_gnt));
         tick();
         chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'h1);
         chk($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(order[k]));
         chk($sformatf("rr%0d_y", k), 32'(rsp_y), 32'(exp_y));
      end
      req = '0;
      tick();

      // 4. Settle time 3 on the second instance, requester 2, a=1 b=0
      req3 = 4'b0100; a3 = 4'b0100; b3 = 4'b0000;
      tick();
      req3 = '0; a3 = '0;
      chk("s3_gnt", 32'(gnt3), 32'h4);
      chk("s3_busy0", 32'(busy3), 32'h1);
      for (int k = 1; k < 3; k++) begin
         tick();
         chk($sformatf("s3_busy%0d", k), 32'(busy3), 32'h1);
         chk($sformatf("s3_novalid%0d", k), 32'(rsp_valid3), 32'h0);
      end
      tick();
      chk("s3_valid", 32'(rsp_valid3), 32'h1);
      chk("s3_y", 32'(rsp_y3), 32'h0);
      chk("s3_id", 32'(rsp_id3), 32'h2);
      chk("s3_busy_done", 32'(busy3), 32'h0);

      // 5. Fault injection: gate stuck at 1 with a=b=1
      force_y = 1'b1;
      req = 4'b0001; a_in = 4'b0001; b_in = 4'b0001;
      tick();
      req = '0;
      chk("flt_gnt", 32'(gnt), 32'h1);
      tick();
      force_y = 1'b0;
      chk("flt_rsp_y", 32'(rsp_y), 32'h1);
      chk("flt_err", 32'(err), 32'h1);
      req = 4'b0100; a_in = '0; b_in = '0;
      tick();
      req = '0;
      tick();
      chk("flt_good_y", 32'(rsp_y), 32'h1);
      chk("flt_err_sticky", 32'(err), 32'h1);
      pulse_reset();
      chk("flt_err_cleared", 32'(err), 32'h0);

      // 6. Reset during DRIVE aborts the op and clears rr_ptr
      req = 4'b0010; a_in = '0; b_in = '0;
      tick();
      req = '0;
      chk("abort_busy_pre", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_gnt", 32'(gnt), 32'h0);
      tick();
      chk("abort_no_valid", 32'(rsp_valid), 32'h0);
      rst_n = 1'b1;
      req = 4'b1010;
      tick();
      chk("abort_rrptr0", 32'(gnt), 32'h2);
      req = 4'b1000;
      tick();
      chk("abort_no_valid2", 32'(rsp_valid) & 32'(rsp_id == 2'd3), 32'h0);
      tick();
      chk("abort_gnt3", 32'(gnt), 32'h8);
      req = '0;
      tick();
      chk("abort_rsp_id3", 32'(rsp_id), 32'h3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
